// File: rtl/wb_regfile_pkg.sv
// Shared writeback types: widths, register address and result-source enum.
// Used by the decoder, MEM/WB register and the writeback/regfile block.
package wb_regfile_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int CNTW  = 64;
  localparam int AW    = $clog2(NREGS);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xword_t;

  typedef enum logic [1:0] {
    RS_ALU = 2'b00,
    RS_MEM = 2'b01,
    RS_PC4 = 2'b10,
    RS_UJ  = 2'b11
  } rslt_src_e;

  function automatic xword_t sel_rslt(
    input rslt_src_e s,
    input xword_t    alu,
    input xword_t    mem,
    input xword_t    pc4,
    input xword_t    uj
  );
    xword_t r;
    r = alu;
    unique case (s)
      RS_ALU: r = alu;
      RS_MEM: r = mem;
      RS_PC4: r = pc4;
      RS_UJ:  r = uj;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// W-stage bundle, decode read ports, forwarding tap and retire count.
// slave = writeback block, master = surrounding pipeline.
interface wb_regfile_if;
  import wb_regfile_pkg::*;

  logic      validw;
  logic      regWrtw;
  logic      memWrtw;
  rslt_src_e rsltSrcw;
  xword_t    readDw;
  xword_t    pc4w;
  xword_t    ujWrtBckw;
  xword_t    aluRsltw;
  reg_addr_t rdw;
  reg_addr_t rs1d;
  reg_addr_t rs2d;
  xword_t    rd1d;
  xword_t    rd2d;
  logic      fwdEnw;
  reg_addr_t fwdRdw;
  xword_t    fwdDataw;
  logic [CNTW-1:0] instret;

  modport slave (
    input  validw, regWrtw, memWrtw, rsltSrcw,
    input  readDw, pc4w, ujWrtBckw, aluRsltw,
    input  rdw, rs1d, rs2d,
    output rd1d, rd2d,
    output fwdEnw, fwdRdw, fwdDataw,
    output instret
  );

  modport master (
    output validw, regWrtw, memWrtw, rsltSrcw,
    output readDw, pc4w, ujWrtBckw, aluRsltw,
    output rdw, rs1d, rs2d,
    input  rd1d, rd2d,
    input  fwdEnw, fwdRdw, fwdDataw,
    input  instret
  );

endinterface

// File: rtl/wb_regfile_regfile_2r1w.sv
// 32x32 integer register file, 2 read / 1 write, x0 hardwired to zero.
// Ports: clk, rst_n, we/wa/wd write, ra1/ra2 -> rd1/rd2 with write-first bypass.
module regfile_2r1w
  import wb_regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      we,
  input  reg_addr_t wa,
  input  xword_t    wd,
  input  reg_addr_t ra1,
  input  reg_addr_t ra2,
  output xword_t    rd1,
  output xword_t    rd2
);

  xword_t mem [NREGS];
  logic   wen;

  // we already carries rst_n; x0 writes are dropped here
  assign wen = we & (wa != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem <= '{default: '0};
    end else if (wen) begin
      mem[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = mem[ra1];
    rd2 = mem[ra2];
    if (wen && ra1 == wa) rd1 = wd;
    if (wen && ra2 == wa) rd2 = wd;
    if (ra1 == '0) rd1 = '0;
    if (ra2 == '0) rd2 = '0;
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result select, regfile write, decode reads,
// forwarding tap and 64-bit retired-instruction counter.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  wb_regfile_if.slave  bus
);

  xword_t          rslt;
  logic            wr;
  logic [CNTW-1:0] cnt_q;

  assign rslt = sel_rslt(bus.rsltSrcw, bus.aluRsltw,
                         bus.readDw, bus.pc4w, bus.ujWrtBckw);

  assign wr = rst_n & bus.validw & bus.regWrtw;

  regfile_2r1w u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr),
    .wa    (bus.rdw),
    .wd    (rslt),
    .ra1   (bus.rs1d),
    .ra2   (bus.rs2d),
    .rd1   (bus.rd1d),
    .rd2   (bus.rd2d)
  );

  assign bus.fwdEnw   = bus.validw & bus.regWrtw
                      & (bus.rdw != '0);
  assign bus.fwdRdw   = bus.rdw;
  assign bus.fwdDataw = rslt;

  // every real instruction retires, stores and x0 writes included
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.validw) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.instret = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam int K_RD1 = 0;
  localparam int K_RD2 = 1;
  localparam int K_FEN = 2;
  localparam int K_FDT = 3;
  localparam int K_CNT = 4;

  typedef struct {
    string       nm;
    int          kind;
    logic [63:0] v;
  } chk_t;

  chk_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic expect_v(input string nm, input int kind,
                          input logic [63:0] v);
    chk_t c;
    c.nm = nm;
    c.kind = kind;
    c.v = v;
    q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] actual(input int kind);
    logic [63:0] a;
    a = '0;
    case (kind)
      K_RD1: a = 64'(bus.rd1d);
      K_RD2: a = 64'(bus.rd2d);
      K_FEN: a = 64'(bus.fwdEnw);
      K_FDT: a = 64'(bus.fwdDataw);
      K_CNT: a = bus.instret;
      default: a = 'x;
    endcase
    return a;
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t c;
      logic [63:0] a;
      c = q.pop_front();
      a = actual(c.kind);
      total++;
      if (a !== c.v) begin
        bad++;
        $display("FAIL %s: got %0h want %0h", c.nm, a, c.v);
      end
    end
  end

  xword_t vals [4];
  logic   pat  [10];

  initial begin
    vals[0] = 32'h11;
    vals[1] = 32'h22;
    vals[2] = 32'h33;
    vals[3] = 32'h44;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
            1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0;
    bus.validw = 1'b1;
    bus.regWrtw = 1'b1;
    bus.memWrtw = 1'b0;
    bus.rsltSrcw = RS_ALU;
    bus.aluRsltw = 32'hAA;
    bus.readDw = 32'h22;
    bus.pc4w = 32'h33;
    bus.ujWrtBckw = 32'h44;
    bus.rdw = 5'd5;
    bus.rs1d = 5'd5;
    bus.rs2d = 5'd0;

    tick();
    expect_v("rst_rd1_in_reset", K_RD1, 64'h0);
    tick();
    rst_n = 1'b1;
    bus.validw = 1'b0;
    expect_v("rst_x5", K_RD1, 64'h0);
    expect_v("rst_cnt", K_CNT, 64'd0);

    bus.aluRsltw = 32'h11;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.validw = 1'b1;
      bus.regWrtw = 1'b1;
      bus.rdw = 5'd7;
      bus.rsltSrcw = rslt_src_e'(i);
      expect_v($sformatf("mux_fen%0d", i), K_FEN, 64'd1);
      expect_v($sformatf("mux_fdata%0d", i), K_FDT, 64'(vals[i]));
      tick();
      bus.validw = 1'b0;
      bus.rs1d = 5'd7;
      expect_v($sformatf("mux_x7_%0d", i), K_RD1, 64'(vals[i]));
    end
    expect_v("mux_cnt", K_CNT, 64'd4);

    tick();
    bus.validw = 1'b1;
    bus.regWrtw = 1'b1;
    bus.rsltSrcw = RS_ALU;
    bus.aluRsltw = 32'hDEADBEEF;
    bus.rdw = 5'd3;
    bus.rs1d = 5'd3;
    bus.rs2d = 5'd3;
    expect_v("byp_rd1", K_RD1, 64'hDEADBEEF);
    expect_v("byp_rd2", K_RD2, 64'hDEADBEEF);

    tick();
    bus.rdw = 5'd0;
    bus.aluRsltw = 32'hFFFFFFFF;
    bus.rs1d = 5'd0;
    expect_v("x0_rd1", K_RD1, 64'h0);
    expect_v("x0_fen", K_FEN, 64'd0);
    expect_v("x3_array", K_RD2, 64'hDEADBEEF);
    tick();
    bus.validw = 1'b0;
    expect_v("x0_rd1_next", K_RD1, 64'h0);
    expect_v("x0_cnt", K_CNT, 64'd6);

    tick();
    bus.validw = 1'b1;
    bus.rdw = 5'd9;
    bus.aluRsltw = 32'h99;
    tick();
    bus.validw = 1'b0;
    bus.aluRsltw = 32'h55;
    bus.rs1d = 5'd9;
    expect_v("bub_fen", K_FEN, 64'd0);
    expect_v("bub_nobyp", K_RD1, 64'h99);
    expect_v("bub_cnt0", K_CNT, 64'd7);
    tick();
    bus.regWrtw = 1'b0;
    expect_v("bub_x9", K_RD1, 64'h99);
    expect_v("bub_cnt1", K_CNT, 64'd7);

    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.rdw = 5'd10;
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.validw = pat[i];
      bus.memWrtw = i[0];
      bus.regWrtw = ~i[0];
    end
    tick();
    bus.validw = 1'b0;
    bus.memWrtw = 1'b0;
    bus.regWrtw = 1'b0;
    bus.rs1d = 5'd3;
    expect_v("cnt_mix", K_CNT, 64'd6);
    expect_v("rst_clr_x3", K_RD1, 64'h0);

    tick();
    force dut.cnt_q = {64{1'b1}};
    #1;
    release dut.cnt_q;
    expect_v("wrap_pre", K_CNT, {64{1'b1}});
    tick();
    bus.validw = 1'b1;
    tick();
    bus.validw = 1'b0;
    expect_v("wrap", K_CNT, 64'd0);

    tick();
    tick();
    if (q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
